jk_bank_ctrl: RTL

Command-driven sequencer for a bank of WIDTH JK flip-flop cells. Each cell has the standard JK truth table: 00 hold, 01 clear, 10 set, 11 toggle. The block accepts one command at a time over a valid/ready handshake and translates it into per-cell j/k vectors, applied over one or more cycles. Multi-cycle operations are increment, decrement and rotate. It serves as the reusable control/status register engine for sequential-logic labs and counters.

---
 rtl/jk_bank_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command-driven sequencer for a bank of JK flip-flop cells.
// One command is accepted at a time over a valid/ready handshake.
// Each command becomes per-cell j/k vectors, applied for one or more cycles.
module jk_bank_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_INCR   = 3'b101;
  localparam logic [2:0] OP_DECR   = 3'b110;
  localparam logic [2:0] OP_ROTL   = 3'b111;

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_accept;
  logic             w_multiStep;
  logic             w_wrapStep;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_incT;
  logic [WIDTH-1:0] w_decT;
  logic [WIDTH-1:0] w_rot;

  assign w_accept    = cmd_valid && cmd_ready;
  assign w_multiStep = cmd_op[2] && (cmd_op[1] || cmd_op[0]);

  // State register: reset always returns the sequencer to IDLE, aborting any command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: accept in IDLE, stay in EXEC until the last step, DONE lasts one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = EXEC;
      EXEC:    if (r_cnt == '0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake and status outputs; ready is forced low while reset is held.
  always_comb begin
    cmd_ready = reset_n && (r_state == IDLE);
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    ovf       = (r_state == DONE) && r_wrap;
  end

  // Toggle vectors for counting and the rotated image; carry chains avoid variable slices.
  always_comb begin
    logic incCarry;
    logic decBorrow;
    incCarry  = 1'b1;
    decBorrow = 1'b1;
    w_incT    = '0;
    w_decT    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_incT[i] = incCarry;
      w_decT[i] = decBorrow;
      incCarry  = incCarry & r_q[i];
      decBorrow = decBorrow & ~r_q[i];
    end
    w_rot = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
  end

  // Per-cell j/k drive from the captured command; everything is zero outside EXEC.
  always_comb begin
    w_j        = '0;
    w_k        = '0;
    w_wrapStep = 1'b0;
    if (r_state == EXEC) begin
      case (r_op)
        OP_HOLD: begin
          w_j = '0;
          w_k = '0;
        end
        OP_CLEAR: begin
          w_k = r_mask;
        end
        OP_SET: begin
          w_j = r_mask;
        end
        OP_TOGGLE: begin
          w_j = r_mask;
          w_k = r_mask;
        end
        OP_LOAD: begin
          w_j = r_mask & r_data;
          w_k = r_mask & ~r_data;
        end
        OP_INCR: begin
          w_j        = w_incT;
          w_k        = w_incT;
          w_wrapStep = &r_q;
        end
        OP_DECR: begin
          w_j        = w_decT;
          w_k        = w_decT;
          w_wrapStep = ~|r_q;
        end
        OP_ROTL: begin
          w_j = w_rot;
          w_k = ~w_rot;
        end
        default: begin
          w_j = '0;
          w_k = '0;
        end
      endcase
    end
  end

  // Datapath: capture the command on accept, then apply the JK equation once per EXEC cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_op   <= OP_HOLD;
      r_mask <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_mask <= cmd_mask;
      r_data <= cmd_data;
      r_cnt  <= w_multiStep ? cmd_cnt : '0;
      r_wrap <= 1'b0;
    end else if (r_state == EXEC) begin
      r_q <= (w_j & ~r_q) | (~w_k & r_q);
      if (w_wrapStep) begin
        r_wrap <= 1'b1;
      end
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign q     = r_q;
  assign qbar  = ~r_q;
  assign j_vec = w_j;
  assign k_vec = w_k;

endmodule
